// File: rtl/mux4_1_stream.sv
// 4-to-1 valid/ready stream merge with round-robin arbitration and one registered output stage.
// Optional per-source saturating transfer counters are enabled by defining MUX_STATS_EN.
module mux4_1_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_STATS_EN
  ,
  input  logic [1:0]       stat_sel,
  output logic [CNT_W-1:0] stat_count
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_src;
  logic [1:0]       r_rr_ptr;

  logic             w_load;
  logic             w_any;
  logic [1:0]       w_grant_idx;
  logic [3:0]       w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  assign w_load = (r_state == StEmpty) || out_ready;

  // Scan from the round-robin pointer; first requester wins.
  always_comb begin
    logic [1:0] w_scan;
    w_any       = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_scan      = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      w_scan = r_rr_ptr + 2'(i);
      if (!w_any && in_valid[w_scan]) begin
        w_any       = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  always_comb begin
    w_grant = 4'b0000;
    if (w_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_xfer   = w_load && w_any && !rst;
  assign in_ready = w_xfer ? w_grant : 4'b0000;

  always_comb begin
    w_mux_data = in_data0;
    unique case (w_grant_idx)
      2'd0: w_mux_data = in_data0;
      2'd1: w_mux_data = in_data1;
      2'd2: w_mux_data = in_data2;
      2'd3: w_mux_data = in_data3;
      default: w_mux_data = in_data0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StEmpty;
      r_data   <= '0;
      r_src    <= 2'd0;
      r_rr_ptr <= 2'd0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_xfer) begin
            r_state  <= StFull;
            r_data   <= w_mux_data;
            r_src    <= w_grant_idx;
            r_rr_ptr <= w_grant_idx + 2'd1;
          end
        end
        StFull: begin
          if (out_ready) begin
            if (w_xfer) begin
              r_data   <= w_mux_data;
              r_src    <= w_grant_idx;
              r_rr_ptr <= w_grant_idx + 2'd1;
            end else begin
              r_state <= StEmpty;
            end
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign out_valid = (r_state == StFull);
  assign out_data  = r_data;
  assign out_src   = r_src;

`ifdef MUX_STATS_EN
  logic [CNT_W-1:0] r_cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (w_xfer && (r_cnt[w_grant_idx] != {CNT_W{1'b1}})) begin
      r_cnt[w_grant_idx] <= r_cnt[w_grant_idx] + 1'b1;
    end
  end

  assign stat_count = r_cnt[stat_sel];
`endif

endmodule
